// File: rtl/csr_uart_fifo.sv
// Buffered 8N1 UART on the CSR bus: DATA / STATUS / CONFIG registers,
// RX and TX FIFOs, programmable divisor, sticky errors and a level irq.
module csr_uart_fifo #(
  parameter logic [11:0] BASE_ADDR  = 12'hBC0,
  parameter int          CLOCK_RATE = 100_000_000,
  parameter int          BAUD_RATE  = 115200,
  parameter int          FIFO_LOG2  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read,
  input  logic [2:0]  modify,
  input  logic [31:0] wdata,
  input  logic [11:0] addr,
  output logic [31:0] rdata,
  output logic        valid,
  input  logic        rx,
  output logic        tx,
  output logic        irq
);

  localparam int DEPTH    = 1 << FIFO_LOG2;
  localparam int DIV_CALC = CLOCK_RATE / BAUD_RATE;
  localparam logic [15:0] RST_DIV =
    (DIV_CALC < 4) ? 16'd4 : 16'(DIV_CALC);

  typedef logic [FIFO_LOG2-1:0] ptr_t;
  typedef logic [FIFO_LOG2:0]   cnt_t;

  localparam ptr_t P1    = ptr_t'(1);
  localparam cnt_t C1    = cnt_t'(1);
  localparam cnt_t CFULL = cnt_t'(DEPTH);

  typedef enum logic {
    TX_IDLE,
    TX_RUN
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT
  } rx_state_t;

  // CSR decode
  logic w_sel_data;
  logic w_sel_stat;
  logic w_sel_cfg;
  logic w_hit;
  logic w_wr_any;
  logic w_wr;
  logic w_unused;

  assign w_sel_data = addr == BASE_ADDR;
  assign w_sel_stat = addr == BASE_ADDR + 12'd1;
  assign w_sel_cfg  = addr == BASE_ADDR + 12'd2;
  assign w_hit      = w_sel_data | w_sel_stat | w_sel_cfg;
  assign w_wr_any   = modify[1:0] != 2'b00;
  assign w_wr       = modify[1:0] == 2'b01;
  assign w_unused   = ^{modify[2], wdata[31:18]};

  // Configuration and sticky state
  logic [15:0] r_div;
  logic        r_rx_ie;
  logic        r_tx_ie;
  logic        r_ovr;
  logic        r_drop;
  logic        r_ferr;
  logic        r_irq;
  logic [31:0] r_rdata;
  logic        r_valid;

  // RX FIFO
  logic [7:0] r_rx_mem [DEPTH];
  ptr_t       r_rx_wp;
  ptr_t       r_rx_rp;
  cnt_t       r_rx_cnt;
  logic       w_rx_empty;
  logic       w_rx_full;
  logic       w_rx_pop;
  logic       w_rx_push;
  logic       w_rx_byte_ok;
  logic       w_ovr_set;
  logic [7:0] w_rx_head;

  // TX FIFO
  logic [7:0] r_tx_mem [DEPTH];
  ptr_t       r_tx_wp;
  ptr_t       r_tx_rp;
  cnt_t       r_tx_cnt;
  logic       w_tx_empty;
  logic       w_tx_full;
  logic       w_tx_pop;
  logic       w_tx_push;
  logic       w_tx_wr;
  logic       w_drop_set;
  logic [7:0] w_tx_head;

  assign w_rx_empty = r_rx_cnt == '0;
  assign w_rx_full  = r_rx_cnt == CFULL;
  assign w_rx_head  = r_rx_mem[r_rx_rp];
  assign w_rx_pop   = read & w_sel_data & ~w_rx_empty;
  assign w_rx_push  = w_rx_byte_ok & (~w_rx_full | w_rx_pop);
  assign w_ovr_set  = w_rx_byte_ok & w_rx_full & ~w_rx_pop;

  assign w_tx_empty = r_tx_cnt == '0;
  assign w_tx_full  = r_tx_cnt == CFULL;
  assign w_tx_head  = r_tx_mem[r_tx_rp];
  assign w_tx_wr    = w_sel_data & w_wr;
  assign w_tx_push  = w_tx_wr & (~w_tx_full | w_tx_pop);
  assign w_drop_set = w_tx_wr & w_tx_full & ~w_tx_pop;

  // RX shifter state
  rx_state_t   r_rx_st;
  rx_state_t   w_rx_st_n;
  logic        r_rx_s1;
  logic        r_rx_s2;
  logic [7:0]  r_rx_sh;
  logic [7:0]  w_rx_sh_n;
  logic [2:0]  r_rx_bit;
  logic [2:0]  w_rx_bit_n;
  logic [15:0] r_rx_tc;
  logic [15:0] w_rx_tc_n;
  logic [15:0] r_rx_div;
  logic [15:0] w_rx_div_n;
  logic        w_ferr_set;

  // TX shifter state
  tx_state_t   r_tx_st;
  tx_state_t   w_tx_st_n;
  logic        r_tx;
  logic        w_tx_n;
  logic [8:0]  r_tx_sh;
  logic [8:0]  w_tx_sh_n;
  logic [3:0]  r_tx_bit;
  logic [3:0]  w_tx_bit_n;
  logic [15:0] r_tx_cnt16;
  logic [15:0] w_tx_cnt16_n;
  logic [15:0] r_tx_div;
  logic [15:0] w_tx_div_n;
  logic        w_tx_idle;

  assign w_tx_idle = w_tx_empty & (r_tx_st == TX_IDLE);

  // FIFO storage, no reset so it can map to RAM
  always_ff @(posedge clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wp] <= r_rx_sh;
    if (w_tx_push) r_tx_mem[r_tx_wp] <= wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_wp  <= '0;
      r_rx_rp  <= '0;
      r_rx_cnt <= '0;
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_tx_cnt <= '0;
    end else begin
      if (w_rx_push) r_rx_wp <= r_rx_wp + P1;
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + P1;
      if (w_rx_push & ~w_rx_pop)
        r_rx_cnt <= r_rx_cnt + C1;
      else if (~w_rx_push & w_rx_pop)
        r_rx_cnt <= r_rx_cnt - C1;
      if (w_tx_push) r_tx_wp <= r_tx_wp + P1;
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + P1;
      if (w_tx_push & ~w_tx_pop)
        r_tx_cnt <= r_tx_cnt + C1;
      else if (~w_tx_push & w_tx_pop)
        r_tx_cnt <= r_tx_cnt - C1;
    end
  end

  // TX: next frame loads right as the previous stop bit ends
  always_comb begin
    w_tx_st_n    = r_tx_st;
    w_tx_n       = r_tx;
    w_tx_sh_n    = r_tx_sh;
    w_tx_bit_n   = r_tx_bit;
    w_tx_cnt16_n = r_tx_cnt16;
    w_tx_div_n   = r_tx_div;
    w_tx_pop     = 1'b0;
    unique case (r_tx_st)
      TX_IDLE: begin
        if (!w_tx_empty) w_tx_pop = 1'b1;
      end
      TX_RUN: begin
        if (r_tx_cnt16 != 16'd0) begin
          w_tx_cnt16_n = r_tx_cnt16 - 16'd1;
        end else if (r_tx_bit == 4'd9) begin
          if (!w_tx_empty) begin
            w_tx_pop = 1'b1;
          end else begin
            w_tx_st_n = TX_IDLE;
            w_tx_n    = 1'b1;
          end
        end else begin
          w_tx_n       = r_tx_sh[0];
          w_tx_sh_n    = {1'b1, r_tx_sh[8:1]};
          w_tx_bit_n   = r_tx_bit + 4'd1;
          w_tx_cnt16_n = r_tx_div - 16'd1;
        end
      end
    endcase
    if (w_tx_pop) begin
      w_tx_st_n    = TX_RUN;
      w_tx_n       = 1'b0;
      w_tx_sh_n    = {1'b1, w_tx_head};
      w_tx_bit_n   = 4'd0;
      w_tx_div_n   = r_div;
      w_tx_cnt16_n = r_div - 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_st    <= TX_IDLE;
      r_tx       <= 1'b1;
      r_tx_sh    <= '1;
      r_tx_bit   <= '0;
      r_tx_cnt16 <= '0;
      r_tx_div   <= RST_DIV;
    end else begin
      r_tx_st    <= w_tx_st_n;
      r_tx       <= w_tx_n;
      r_tx_sh    <= w_tx_sh_n;
      r_tx_bit   <= w_tx_bit_n;
      r_tx_cnt16 <= w_tx_cnt16_n;
      r_tx_div   <= w_tx_div_n;
    end
  end

  // RX: start confirmed at half a bit, data at bit centres
  always_comb begin
    w_rx_st_n    = r_rx_st;
    w_rx_sh_n    = r_rx_sh;
    w_rx_bit_n   = r_rx_bit;
    w_rx_tc_n    = r_rx_tc;
    w_rx_div_n   = r_rx_div;
    w_rx_byte_ok = 1'b0;
    w_ferr_set   = 1'b0;
    unique case (r_rx_st)
      RX_IDLE: begin
        if (!r_rx_s2) begin
          w_rx_st_n  = RX_START;
          w_rx_div_n = r_div;
          w_rx_tc_n  = {1'b0, r_div[15:1]} - 16'd1;
        end
      end
      RX_START: begin
        if (r_rx_tc != 16'd0) begin
          w_rx_tc_n = r_rx_tc - 16'd1;
        end else if (r_rx_s2) begin
          w_rx_st_n = RX_IDLE;
        end else begin
          w_rx_st_n  = RX_DATA;
          w_rx_bit_n = 3'd0;
          w_rx_tc_n  = r_rx_div - 16'd1;
        end
      end
      RX_DATA: begin
        if (r_rx_tc != 16'd0) begin
          w_rx_tc_n = r_rx_tc - 16'd1;
        end else begin
          w_rx_sh_n = {r_rx_s2, r_rx_sh[7:1]};
          w_rx_tc_n = r_rx_div - 16'd1;
          if (r_rx_bit == 3'd7) w_rx_st_n = RX_STOP;
          else w_rx_bit_n = r_rx_bit + 3'd1;
        end
      end
      RX_STOP: begin
        if (r_rx_tc != 16'd0) begin
          w_rx_tc_n = r_rx_tc - 16'd1;
        end else if (r_rx_s2) begin
          w_rx_byte_ok = 1'b1;
          w_rx_st_n    = RX_IDLE;
        end else begin
          w_ferr_set = 1'b1;
          w_rx_st_n  = RX_WAIT;
        end
      end
      RX_WAIT: begin
        if (r_rx_s2) w_rx_st_n = RX_IDLE;
      end
      default: w_rx_st_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_s1  <= 1'b1;
      r_rx_s2  <= 1'b1;
      r_rx_st  <= RX_IDLE;
      r_rx_sh  <= '0;
      r_rx_bit <= '0;
      r_rx_tc  <= '0;
      r_rx_div <= RST_DIV;
    end else begin
      r_rx_s1  <= rx;
      r_rx_s2  <= r_rx_s1;
      r_rx_st  <= w_rx_st_n;
      r_rx_sh  <= w_rx_sh_n;
      r_rx_bit <= w_rx_bit_n;
      r_rx_tc  <= w_rx_tc_n;
      r_rx_div <= w_rx_div_n;
    end
  end

  // CONFIG update and read mux
  logic [17:0] w_cfg_cur;
  logic [17:0] w_cfg_new;
  logic [2:0]  w_clr;
  logic [31:0] w_rd;
  logic [7:0]  w_rx_cnt8;
  logic [7:0]  w_tx_cnt8;

  assign w_cfg_cur = {r_tx_ie, r_rx_ie, r_div};
  assign w_clr     = (w_sel_stat & w_wr_any) ? wdata[4:2] : 3'b000;
  assign w_rx_cnt8 = 8'(r_rx_cnt);
  assign w_tx_cnt8 = 8'(r_tx_cnt);

  always_comb begin
    w_cfg_new = w_cfg_cur;
    unique case (modify[1:0])
      2'b01:   w_cfg_new = wdata[17:0];
      2'b10:   w_cfg_new = w_cfg_cur | wdata[17:0];
      2'b11:   w_cfg_new = w_cfg_cur & ~wdata[17:0];
      default: w_cfg_new = w_cfg_cur;
    endcase
  end

  always_comb begin
    w_rd = '0;
    unique case (1'b1)
      w_sel_data: w_rd = {23'd0, w_rx_empty,
                          w_rx_empty ? 8'h00 : w_rx_head};
      w_sel_stat: w_rd = {8'd0, w_tx_cnt8, w_rx_cnt8, 2'b00,
                          w_tx_idle, r_ferr, r_drop, r_ovr,
                          w_tx_full, ~w_rx_empty};
      w_sel_cfg:  w_rd = {14'd0, w_cfg_cur};
      default:    w_rd = '0;
    endcase
  end

  // A new error in the same cycle as its W1C wins so no event is lost
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div   <= RST_DIV;
      r_rx_ie <= 1'b0;
      r_tx_ie <= 1'b0;
      r_ovr   <= 1'b0;
      r_drop  <= 1'b0;
      r_ferr  <= 1'b0;
      r_rdata <= '0;
      r_valid <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      if (w_sel_cfg & w_wr_any) begin
        r_div   <= (w_cfg_new[15:0] < 16'd4) ? 16'd4
                                             : w_cfg_new[15:0];
        r_rx_ie <= w_cfg_new[16];
        r_tx_ie <= w_cfg_new[17];
      end
      r_ovr   <= (r_ovr & ~w_clr[0]) | w_ovr_set;
      r_drop  <= (r_drop & ~w_clr[1]) | w_drop_set;
      r_ferr  <= (r_ferr & ~w_clr[2]) | w_ferr_set;
      r_rdata <= w_rd;
      r_valid <= w_hit;
      r_irq   <= (r_rx_ie & ~w_rx_empty) | (r_tx_ie & w_tx_idle);
    end
  end

  assign rdata = r_rdata;
  assign valid = r_valid;
  assign tx    = r_tx;
  assign irq   = r_irq;

endmodule

// File: tb/tb_csr_uart_fifo.sv
// Directed bench for csr_uart_fifo: CSR access, TX framing, RX paths,
// FIFO limits, sticky flags, interrupt and mid-frame reset.
module tb_csr_uart_fifo;

  localparam logic [11:0] A_DATA = 12'hBC0;
  localparam logic [11:0] A_STAT = 12'hBC1;
  localparam logic [11:0] A_CFG  = 12'hBC2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        read = 1'b0;
  logic [2:0]  modify = 3'b000;
  logic [31:0] wdata = '0;
  logic [11:0] addr = '0;
  logic [31:0] rdata;
  logic        valid;
  logic        rx;
  logic        tx;
  logic        irq;
  logic        loop_en = 1'b0;
  logic        rx_drv = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  assign rx = loop_en ? tx : rx_drv;

  always #5 clk = ~clk;

  csr_uart_fifo #(
    .BASE_ADDR (12'hBC0),
    .CLOCK_RATE(100_000_000),
    .BAUD_RATE (115200),
    .FIFO_LOG2 (2)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .read  (read),
    .modify(modify),
    .wdata (wdata),
    .addr  (addr),
    .rdata (rdata),
    .valid (valid),
    .rx    (rx),
    .tx    (tx),
    .irq   (irq)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One CSR access; called at a negedge, returns at the next negedge
  task automatic csr(input logic rd, input logic [1:0] md,
                     input logic [11:0] a, input logic [31:0] wd,
                     output logic [31:0] q);
    read   = rd;
    modify = {1'b0, md};
    addr   = a;
    wdata  = wd;
    @(posedge clk);
    @(negedge clk);
    q      = rdata;
    read   = 1'b0;
    modify = 3'b000;
    addr   = '0;
    wdata  = '0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop,
                           input int bc);
    rx_drv = 1'b0;
    repeat (bc) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (bc) @(negedge clk);
    end
    rx_drv = stop;
    repeat (bc) @(negedge clk);
    rx_drv = 1'b1;
    repeat (bc) @(negedge clk);
  endtask

  // Decodes one divisor-4 frame from tx; to=1 if no start bit appears
  task automatic cap_frame(output logic [8:0] f, output bit to);
    int n = 0;
    to = 1'b0;
    f  = '1;
    while (tx !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      to = 1'b1;
    end else begin
      repeat (2) @(negedge clk);
      for (int b = 0; b < 9; b++) begin
        repeat (4) @(negedge clk);
        f[b] = tx;
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] q;
    logic [9:0]  frame;
    logic [3:0]  s;
    logic [7:0]  lb [4];
    logic [7:0]  inj [5];
    logic [7:0]  dexp [5];
    logic [8:0]  cap [6];
    bit          cto [6];

    lb   = '{8'h00, 8'hFF, 8'hA5, 8'h3C};
    inj  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    dexp = '{8'h01, 8'h10, 8'h11, 8'h12, 8'h13};

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_rdata", rdata, 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    csr(1'b1, 2'b00, A_CFG, 32'd0, q);
    check("rst_cfg", q, 32'd868);
    check("cfg_valid", 32'(valid), 32'd1);
    csr(1'b1, 2'b00, A_STAT, 32'd0, q);
    check("rst_stat", q, 32'h20);
    csr(1'b1, 2'b00, 12'hBC3, 32'd0, q);
    check("miss_valid", 32'(valid), 32'd0);
    check("miss_rdata", q, 32'd0);

    // TX framing of 0x55 at divisor 4
    csr(1'b0, 2'b01, A_CFG, 32'd4, q);
    csr(1'b1, 2'b00, A_CFG, 32'd0, q);
    check("cfg_div4", q, 32'd4);
    csr(1'b0, 2'b01, A_DATA, 32'h55, q);
    check("tx_n1_high", 32'(tx), 32'd1);
    frame = {1'b1, 8'h55, 1'b0};
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        s[c] = tx;
      end
      check($sformatf("tx55_bit%0d", b), 32'(s), {28'd0, {4{frame[b]}}});
    end
    @(negedge clk);
    csr(1'b1, 2'b00, A_STAT, 32'd0, q);
    check("tx_idle_after", q, 32'h20);

    // Loopback of four bytes through both FIFOs
    loop_en = 1'b1;
    for (int i = 0; i < 4; i++)
      csr(1'b0, 2'b01, A_DATA, 32'(lb[i]), q);
    for (int i = 0; i < 400; i++) begin
      csr(1'b1, 2'b00, A_STAT, 32'd0, q);
      if (q[15:8] == 8'd4) break;
    end
    check("lb_rxcnt", 32'(q[15:8]), 32'd4);
    for (int i = 0; i < 4; i++) begin
      csr(1'b1, 2'b00, A_DATA, 32'd0, q);
      check($sformatf("lb_byte%0d", i), q, 32'(lb[i]));
    end
    csr(1'b1, 2'b00, A_DATA, 32'd0, q);
    check("lb_empty", q, 32'h100);
    repeat (8) @(negedge clk);
    loop_en = 1'b0;

    // RX overrun with depth 4
    for (int i = 0; i < 5; i++) send_byte(inj[i], 1'b1, 4);
    repeat (8) @(negedge clk);
    csr(1'b1, 2'b00, A_STAT, 32'd0, q);
    check("ovr_stat", q, 32'h0425);
    csr(1'b0, 2'b01, A_STAT, 32'h4, q);
    csr(1'b1, 2'b00, A_STAT, 32'd0, q);
    check("ovr_w1c", q, 32'h0421);
    for (int i = 0; i < 4; i++) begin
      csr(1'b1, 2'b00, A_DATA, 32'd0, q);
      check($sformatf("ovr_byte%0d", i), q, 32'(inj[i]));
    end
    csr(1'b1, 2'b00, A_DATA, 32'd0, q);
    check("ovr_empty", q, 32'h100);

    // TX drop: five writes while a frame is on the line
    fork
      begin
        for (int i = 0; i < 6; i++) cap_frame(cap[i], cto[i]);
      end
      begin
        csr(1'b0, 2'b01, A_DATA, 32'h01, q);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++)
          csr(1'b0, 2'b01, A_DATA, 32'h10 + 32'(i), q);
        csr(1'b1, 2'b00, A_STAT, 32'd0, q);
        check("drop_stat", q, 32'h0004000A);
      end
    join
    for (int i = 0; i < 5; i++)
      check($sformatf("drop_frame%0d", i), 32'(cap[i]),
            32'({1'b1, dexp[i]}));
    check("drop_absent", 32'(cto[5]), 32'd1);
    csr(1'b0, 2'b01, A_STAT, 32'h1C, q);
    csr(1'b1, 2'b00, A_STAT, 32'd0, q);
    check("drop_w1c", q, 32'h20);

    // Framing error, then glitch rejection at divisor 16
    send_byte(8'hA5, 1'b0, 4);
    repeat (4) @(negedge clk);
    csr(1'b1, 2'b00, A_STAT, 32'd0, q);
    check("ferr_stat", q, 32'h30);
    csr(1'b0, 2'b11, A_STAT, 32'h10, q);
    csr(1'b0, 2'b01, A_CFG, 32'd16, q);
    rx_drv = 1'b0;
    repeat (2) @(negedge clk);
    rx_drv = 1'b1;
    repeat (40) @(negedge clk);
    csr(1'b1, 2'b00, A_STAT, 32'd0, q);
    check("glitch_stat", q, 32'h20);
    send_byte(8'h3C, 1'b1, 16);
    repeat (8) @(negedge clk);
    csr(1'b1, 2'b00, A_DATA, 32'd0, q);
    check("div16_byte", q, 32'h3C);

    // Divisor floor, set mode and rx interrupt
    csr(1'b0, 2'b01, A_CFG, 32'd2, q);
    csr(1'b1, 2'b00, A_CFG, 32'd0, q);
    check("cfg_floor", q, 32'd4);
    csr(1'b0, 2'b10, A_CFG, 32'h10000, q);
    csr(1'b1, 2'b00, A_CFG, 32'd0, q);
    check("cfg_set", q, 32'h10004);
    check("irq_quiet", 32'(irq), 32'd0);
    send_byte(8'h7E, 1'b1, 4);
    repeat (4) @(negedge clk);
    check("irq_rx", 32'(irq), 32'd1);
    csr(1'b1, 2'b00, A_DATA, 32'd0, q);
    check("irq_byte", q, 32'h7E);
    check("irq_hold", 32'(irq), 32'd1);
    @(negedge clk);
    check("irq_drop", 32'(irq), 32'd0);

    // Reset in the middle of a frame
    csr(1'b0, 2'b01, A_DATA, 32'h00, q);
    repeat (5) @(negedge clk);
    check("mid_tx_low", 32'(tx), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_tx", 32'(tx), 32'd1);
    rst = 1'b0;
    csr(1'b1, 2'b00, A_STAT, 32'd0, q);
    check("mid_rst_stat", q, 32'h20);
    csr(1'b1, 2'b00, A_CFG, 32'd0, q);
    check("mid_rst_cfg", q, 32'd868);

    // tx interrupt when idle
    csr(1'b0, 2'b10, A_CFG, 32'h20000, q);
    @(negedge clk);
    check("irq_tx", 32'(irq), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
